// File: rtl/shift_add_mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// operand width, iteration counter width and the controller state type.
package mul_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/shift_add_mul_adder.sv
// fulladder32: 32-bit ripple-carry adder.
// It is the only adder in the multiplier datapath and is reused on every iteration.
module fulladder32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        carry_i,
  output logic [31:0] sum_o,
  output logic        carry_o
);

  logic [32:0] c;

  assign c[0] = carry_i;

  // One full-adder cell per bit; the carry ripples from LSB to MSB.
  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign carry_o = c[32];

endmodule

// File: rtl/shift_add_mul.sv
// shift_add_mul: 32x32 -> 64 unsigned sequential multiplier.
// Each BUSY cycle does one conditional add of the multiplicand into the upper
// accumulator half, then shifts {carry, sum, multiplier} right by one bit.
// A product takes 32 iterations. The valid_o pulse arrives 33 cycles after accept.
// Optional build macro MUL_ZERO_BYPASS_EN: when a zero operand is accepted,
// the unit skips the iterations and reports a zero product on the next cycle.
module shift_add_mul
  import mul_pkg::*;
#(
  parameter int XLEN = mul_pkg::XLEN
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [2*XLEN-1:0] result_o
);

  if (XLEN != 32) begin : g_bad_xlen
    $error("shift_add_mul: only XLEN=32 is supported (got %0d)", XLEN);
  end

  mul_state_t       state_q;
  logic [XLEN-1:0]  mcand_q;
  logic [XLEN-1:0]  acc_hi_q;
  logic [XLEN-1:0]  mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             valid_q;
  logic [2*XLEN-1:0] result_q;

  logic [XLEN-1:0]  addend;
  logic [XLEN-1:0]  sum;
  logic             carry;
  logic [XLEN-1:0]  acc_hi_d;
  logic [XLEN-1:0]  mplier_d;
  logic             zero_bypass;

  // Add the multiplicand only when the current multiplier LSB is set.
  always_comb begin
    addend = mplier_q[0] ? mcand_q : '0;
  end

  fulladder32 u_adder (
    .a_i     (acc_hi_q),
    .b_i     (addend),
    .carry_i (1'b0),
    .sum_o   (sum),
    .carry_o (carry)
  );

  // Right shift of {carry, sum, multiplier}. The adder carry lands in the top
  // accumulator bit, so no overflow bit is ever dropped.
  always_comb begin
    acc_hi_d = {carry, sum[XLEN-1:1]};
    mplier_d = {sum[0], mplier_q[XLEN-1:1]};
  end

  // Decide whether an accepted request may skip straight to DONE.
  always_comb begin
`ifdef MUL_ZERO_BYPASS_EN
    zero_bypass = (a_i == '0) || (b_i == '0);
`else
    zero_bypass = 1'b0;
`endif
  end

  // Controller, datapath registers and registered handshake outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (start_i) begin
            ready_q <= 1'b0;
            cnt_q   <= '0;
            if (zero_bypass) begin
              mcand_q  <= '0;
              acc_hi_q <= '0;
              mplier_q <= '0;
              result_q <= '0;
              valid_q  <= 1'b1;
              state_q  <= DONE;
            end else begin
              mcand_q  <= a_i;
              mplier_q <= b_i;
              acc_hi_q <= '0;
              state_q  <= BUSY;
            end
          end
        end
        BUSY: begin
          acc_hi_q <= acc_hi_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            // Publish the final product together with the valid pulse.
            result_q <= {acc_hi_d, mplier_d};
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_shift_add_mul.sv
// Directed self-checking bench for shift_add_mul.
module tb_shift_add_mul;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        ready_o;
  logic        valid_o;
  logic [63:0] result_o;

  int tests  = 0;
  int failed = 0;

`ifdef MUL_ZERO_BYPASS_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 33;
`endif

  shift_add_mul dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request for a single cycle, then wait for valid_o.
  // Checks latency, result, ready_o low while busy, and the return to idle.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int exp_lat);
    int cyc;
    logic ready_bad;
    start_i = 1'b1; a_i = a; b_i = b;
    tick();
    start_i = 1'b0; a_i = '0; b_i = '0;
    cyc = 1;
    ready_bad = 1'b0;
    while (valid_o !== 1'b1 && cyc < 60) begin
      if (ready_o !== 1'b0) ready_bad = 1'b1;
      tick();
      cyc++;
    end
    if (ready_o !== 1'b0) ready_bad = 1'b1;
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_result"}, result_o, exp);
    chk({tag, "_ready_low_while_busy"}, 64'(ready_bad), 64'd0);
    tick();
    chk({tag, "_valid_one_cycle"}, 64'(valid_o), 64'd0);
    chk({tag, "_ready_after"}, 64'(ready_o), 64'd1);
  endtask

  initial begin
    int cyc;
    logic bad;
    rst_i = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0;
    #1;
    chk("reset_ready", 64'(ready_o), 64'd1);
    chk("reset_valid", 64'(valid_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    tick(); tick();
    #2 rst_i = 1'b0;
    tick();

    // Basic product.
    run_op("mul_3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 33);
    tick(); tick();
    chk("result_held", result_o, 64'h0000_0000_0000_000F);

    // Carry out of the adder on every iteration.
    run_op("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33);
    run_op("mul_mixed", 32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080, 33);

    // Start while busy must be ignored.
    start_i = 1'b1; a_i = 32'd7; b_i = 32'd9;
    tick();
    start_i = 1'b0;
    bad = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      if (ready_o !== 1'b0 || valid_o !== 1'b0) bad = 1'b1;
      if (c == 10) begin start_i = 1'b1; a_i = 32'd2; b_i = 32'd2; end
      else begin start_i = 1'b0; a_i = '0; b_i = '0; end
      tick();
    end
    chk("busy_ignore_ready_low", 64'(bad), 64'd0);
    chk("busy_ignore_valid33", 64'(valid_o), 64'd1);
    chk("busy_ignore_ready33", 64'(ready_o), 64'd0);
    chk("busy_ignore_result", result_o, 64'd63);
    tick();
    chk("busy_ignore_idle34", 64'(ready_o), 64'd1);
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (valid_o !== 1'b0 || ready_o !== 1'b1) bad = 1'b1;
    end
    chk("busy_ignore_no_queue", 64'(bad), 64'd0);

    // start_i held high: back-to-back accepts at cycles 0 and 34.
    start_i = 1'b1; a_i = 32'h0001_0000; b_i = 32'h0001_0000;
    tick();
    for (int c = 1; c < 33; c++) tick();
    chk("held_valid33", 64'(valid_o), 64'd1);
    chk("held_result1", result_o, 64'h0000_0001_0000_0000);
    tick();
    chk("held_ready34", 64'(ready_o), 64'd1);
    tick();
    chk("held_accept34", 64'(ready_o), 64'd0);
    for (int c = 35; c < 67; c++) tick();
    start_i = 1'b0;
    chk("held_valid67", 64'(valid_o), 64'd1);
    chk("held_result2", result_o, 64'h0000_0001_0000_0000);
    tick();

    // Reset during BUSY discards the product.
    start_i = 1'b1; a_i = 32'd3; b_i = 32'd5;
    tick();
    start_i = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_ready", 64'(ready_o), 64'd1);
    chk("midrst_valid", 64'(valid_o), 64'd0);
    chk("midrst_result", result_o, 64'd0);
    tick();
    #2 rst_i = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (valid_o !== 1'b0 || ready_o !== 1'b1) bad = 1'b1;
    end
    chk("midrst_no_valid", 64'(bad), 64'd0);

    // Zero operands: bypassed or full-length depending on build.
    run_op("zero_a", 32'd0, 32'h0000_1234, 64'd0, ZERO_LAT);
    run_op("zero_b", 32'hDEAD_BEEF, 32'd0, 64'd0, ZERO_LAT);
    run_op("after_zero", 32'd6, 32'd7, 64'd42, 33);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
